// File: rtl/romload_pkg.sv
// romload_pkg: shared types for the ROM-load arbiter.
//   romload_state_t : arbiter FSM states
//   romload_wr_t    : buffered download write {addr, data}
//   ROMLOAD_AW      : default ROM RAM address width (also the buffer address width)
//   ROMLOAD_DW      : ROM RAM data width
package romload_pkg;

  localparam int unsigned ROMLOAD_AW = 12;
  localparam int unsigned ROMLOAD_DW = 8;
  localparam int unsigned ROMLOAD_CW = 4;   // defer counter width, covers MAX_DEFER up to 15

  typedef enum logic [1:0] {IDLE, RD1, RD2, WR} romload_state_t;

  typedef struct packed {
    logic [ROMLOAD_AW-1:0] addr;
    logic [ROMLOAD_DW-1:0] data;
  } romload_wr_t;

endpackage

// File: rtl/romload_wbuf.sv
// romload_wbuf: one-entry download write buffer. Its valid flag is the DL_WAIT source.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : capture i_wr when empty (ignored while full)
//   i_pop     : drop the entry (issued when the write is granted)
//   i_wr      : incoming {addr, data}
//   o_valid   : entry held
//   o_wr      : held {addr, data}
module romload_wbuf
  import romload_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  romload_wr_t i_wr,
  output logic        o_valid,
  output romload_wr_t o_wr
);

  logic        r_valid;
  romload_wr_t r_wr;

  // Push and pop never coincide: a push needs the buffer empty, a pop needs it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wr    <= '0;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end else if (i_push && !r_valid) begin
      r_valid <= 1'b1;
      r_wr    <= i_wr;
    end
  end

  assign o_valid = r_valid;
  assign o_wr    = r_wr;

endmodule

// File: rtl/romload_arb.sv
// romload_arb: shares one single-port synchronous ROM RAM between the ioctl
// download writer and the CPU fetch port. CPU reads win arbitration until
// MAX_DEFER reads have been granted over a pending write; then the write goes.
// Optional feature macro: ROMLOAD_CKSUM_EN adds a 16-bit CKSUM output
// (wrapping sum of accepted download bytes, cleared on DL_ACTIVE rising).
// Ports:
//   CLK_SYS, RESET        : clock, asynchronous active-high reset
//   DL_ACTIVE             : download in progress
//   DL_WR/DL_ADDR/DL_DATA : download byte strobe/address/data
//   DL_WAIT               : write buffer full, host holds its strobe
//   DL_DONE               : one-cycle pulse once the download ended and drained
//   CPU_RD/CPU_ADDR       : level read request and address
//   CPU_DATA/CPU_ACK      : read data (held) and one-cycle completion pulse
//   MEM_EN/MEM_WE/MEM_ADDR/MEM_DIN : registered RAM controls
//   MEM_DOUT              : RAM read data, one cycle after MEM_EN
//   CKSUM                 : (ROMLOAD_CKSUM_EN only) download byte checksum
module romload_arb
  import romload_pkg::*;
#(
  parameter int unsigned AW        = ROMLOAD_AW,
  parameter int unsigned MAX_DEFER = 4
) (
  input  logic                  CLK_SYS,
  input  logic                  RESET,
  input  logic                  DL_ACTIVE,
  input  logic                  DL_WR,
  input  logic [AW-1:0]         DL_ADDR,
  input  logic [ROMLOAD_DW-1:0] DL_DATA,
  output logic                  DL_WAIT,
  output logic                  DL_DONE,
  input  logic                  CPU_RD,
  input  logic [AW-1:0]         CPU_ADDR,
  output logic [ROMLOAD_DW-1:0] CPU_DATA,
  output logic                  CPU_ACK,
  output logic                  MEM_EN,
  output logic                  MEM_WE,
  output logic [AW-1:0]         MEM_ADDR,
  output logic [ROMLOAD_DW-1:0] MEM_DIN,
  input  logic [ROMLOAD_DW-1:0] MEM_DOUT
`ifdef ROMLOAD_CKSUM_EN
  ,
  output logic [15:0]           CKSUM
`endif
);

  romload_state_t        r_state;
  logic [ROMLOAD_CW-1:0] r_defer_cnt;
  logic                  r_dl_seen;
  logic                  w_wbuf_valid;
  logic                  w_push;
  logic                  w_rd_grant;
  logic                  w_wr_grant;
  romload_wr_t           w_wbuf;
  romload_wr_t           w_wr_in;

  always_comb begin
    w_wr_in      = '0;
    w_wr_in.addr = ROMLOAD_AW'(DL_ADDR);
    w_wr_in.data = DL_DATA;
  end

  assign w_push  = DL_WR & ~w_wbuf_valid;
  assign DL_WAIT = w_wbuf_valid;

  // Read first, unless a write has already been passed over MAX_DEFER times.
  assign w_rd_grant = (r_state == IDLE) & CPU_RD &
                      (~w_wbuf_valid | (r_defer_cnt < ROMLOAD_CW'(MAX_DEFER)));
  assign w_wr_grant = (r_state == IDLE) & ~w_rd_grant & w_wbuf_valid;

  romload_wbuf u_wbuf (
    .clk     (CLK_SYS),
    .rst     (RESET),
    .i_push  (w_push),
    .i_pop   (w_wr_grant),
    .i_wr    (w_wr_in),
    .o_valid (w_wbuf_valid),
    .o_wr    (w_wbuf)
  );

  // Arbiter FSM: exactly one RAM operation per visit to RD1 or WR.
  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_defer_cnt <= '0;
      MEM_EN      <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_DIN     <= '0;
      CPU_DATA    <= '0;
      CPU_ACK     <= 1'b0;
    end else begin
      CPU_ACK <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rd_grant) begin
            MEM_EN      <= 1'b1;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= CPU_ADDR;
            r_defer_cnt <= r_defer_cnt + ROMLOAD_CW'(w_wbuf_valid);
            r_state     <= RD1;
          end else if (w_wr_grant) begin
            MEM_EN      <= 1'b1;
            MEM_WE      <= 1'b1;
            MEM_ADDR    <= AW'(w_wbuf.addr);
            MEM_DIN     <= w_wbuf.data;
            r_defer_cnt <= '0;
            r_state     <= WR;
          end
        end
        RD1: begin
          MEM_EN  <= 1'b0;
          r_state <= RD2;
        end
        RD2: begin
          CPU_DATA <= MEM_DOUT;
          CPU_ACK  <= 1'b1;
          r_state  <= IDLE;
        end
        WR: begin
          MEM_EN  <= 1'b0;
          MEM_WE  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Done flag: armed while the download runs, fires once the last byte is in RAM.
  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      r_dl_seen <= 1'b0;
      DL_DONE   <= 1'b0;
    end else begin
      DL_DONE <= 1'b0;
      if (DL_ACTIVE) begin
        r_dl_seen <= 1'b1;
      end else if (r_dl_seen && !w_wbuf_valid && (r_state != WR)) begin
        DL_DONE   <= 1'b1;
        r_dl_seen <= 1'b0;
      end
    end
  end

`ifdef ROMLOAD_CKSUM_EN
  logic        r_dl_active_q;
  logic [15:0] r_cksum;

  // Sum of accepted bytes; a byte accepted on the rising-edge cycle starts the new sum.
  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      r_dl_active_q <= 1'b0;
      r_cksum       <= '0;
    end else begin
      r_dl_active_q <= DL_ACTIVE;
      if (DL_ACTIVE && !r_dl_active_q) begin
        r_cksum <= w_push ? 16'(DL_DATA) : 16'h0000;
      end else if (w_push) begin
        r_cksum <= r_cksum + 16'(DL_DATA);
      end
    end
  end

  assign CKSUM = r_cksum;
`endif

endmodule

// File: tb/tb_romload_arb.sv
// tb_romload_arb: directed self-checking bench for romload_arb with a
// behavioural single-port synchronous RAM behind the MEM_* port.
// Define ROMLOAD_CKSUM_EN to also exercise the CKSUM output.
module tb_romload_arb;

  logic        CLK_SYS = 1'b0;
  logic        RESET;
  logic        DL_ACTIVE, DL_WR;
  logic [11:0] DL_ADDR;
  logic [7:0]  DL_DATA;
  logic        DL_WAIT, DL_DONE;
  logic        CPU_RD;
  logic [11:0] CPU_ADDR;
  logic [7:0]  CPU_DATA;
  logic        CPU_ACK;
  logic        MEM_EN, MEM_WE;
  logic [11:0] MEM_ADDR;
  logic [7:0]  MEM_DIN, MEM_DOUT;
`ifdef ROMLOAD_CKSUM_EN
  logic [15:0] CKSUM;
`endif

  int checks = 0;
  int errors = 0;

  // RAM model with a preload port used only while the DUT is held in reset.
  logic [7:0]  ram [0:4095];
  logic [7:0]  ram_dout;
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  int          wr_cnt = 0;

  assign MEM_DOUT = ram_dout;

  always #5 CLK_SYS = ~CLK_SYS;

  always @(posedge CLK_SYS) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (MEM_EN) begin
      if (MEM_WE) ram[MEM_ADDR] <= MEM_DIN;
      else        ram_dout <= ram[MEM_ADDR];
    end
  end

  always @(posedge CLK_SYS) if (MEM_EN && MEM_WE) wr_cnt <= wr_cnt + 1;

  romload_arb #(.AW(12), .MAX_DEFER(4)) dut (
    .CLK_SYS   (CLK_SYS),
    .RESET     (RESET),
    .DL_ACTIVE (DL_ACTIVE),
    .DL_WR     (DL_WR),
    .DL_ADDR   (DL_ADDR),
    .DL_DATA   (DL_DATA),
    .DL_WAIT   (DL_WAIT),
    .DL_DONE   (DL_DONE),
    .CPU_RD    (CPU_RD),
    .CPU_ADDR  (CPU_ADDR),
    .CPU_DATA  (CPU_DATA),
    .CPU_ACK   (CPU_ACK),
    .MEM_EN    (MEM_EN),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DIN   (MEM_DIN),
    .MEM_DOUT  (MEM_DOUT)
`ifdef ROMLOAD_CKSUM_EN
    ,
    .CKSUM     (CKSUM)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_SYS);
    #1;
  endtask

  task automatic wait_ack(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (CPU_ACK) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Host side of the download handshake: hold the byte until DL_WAIT is low.
  task automatic push_byte(input logic [11:0] a, input logic [7:0] d, output logic ok);
    DL_WR   = 1'b1;
    DL_ADDR = a;
    DL_DATA = d;
    ok      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!DL_WAIT) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    DL_WR = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   rd_pend, got_wr, bad, push_fail, w0, pulses;

    RESET = 1'b1; DL_ACTIVE = 1'b0; DL_WR = 1'b0; DL_ADDR = '0; DL_DATA = '0;
    CPU_RD = 1'b0; CPU_ADDR = '0;
    pl_en = 1'b1; pl_addr = 12'h123; pl_data = 8'hA5;
    step();
    pl_en = 1'b0;
    step();

    // Reset values
    chk("rst_mem_en",   MEM_EN,   0);
    chk("rst_mem_we",   MEM_WE,   0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    chk("rst_mem_din",  MEM_DIN,  0);
    chk("rst_cpu_ack",  CPU_ACK,  0);
    chk("rst_cpu_data", CPU_DATA, 0);
    chk("rst_dl_wait",  DL_WAIT,  0);
    chk("rst_dl_done",  DL_DONE,  0);
    RESET = 1'b0;
    step();

    // Read alone: MEM_EN at cycle 1, ack with data at cycle 3
    CPU_RD = 1'b1; CPU_ADDR = 12'h123;
    step();
    chk("rd_c1_en",   MEM_EN,   1);
    chk("rd_c1_we",   MEM_WE,   0);
    chk("rd_c1_addr", MEM_ADDR, 12'h123);
    chk("rd_c1_ack",  CPU_ACK,  0);
    step();
    chk("rd_c2_en",   MEM_EN,   0);
    chk("rd_c2_ack",  CPU_ACK,  0);
    step();
    chk("rd_c3_ack",  CPU_ACK,  1);
    chk("rd_c3_data", CPU_DATA, 8'hA5);
    CPU_RD = 1'b0;
    step();
    chk("rd_c4_ack",  CPU_ACK,  0);
    chk("rd_c4_en",   MEM_EN,   0);
    chk("rd_c4_data_held", CPU_DATA, 8'hA5);

    // Write alone: DL_WAIT at cycle 1, RAM write and DL_WAIT low at cycle 2
    DL_ACTIVE = 1'b1;
    DL_WR = 1'b1; DL_ADDR = 12'h010; DL_DATA = 8'h3C;
    step();
    DL_WR = 1'b0;
    chk("wr_c1_wait", DL_WAIT, 1);
    chk("wr_c1_en",   MEM_EN,  0);
    step();
    chk("wr_c2_en",   MEM_EN,   1);
    chk("wr_c2_we",   MEM_WE,   1);
    chk("wr_c2_addr", MEM_ADDR, 12'h010);
    chk("wr_c2_din",  MEM_DIN,  8'h3C);
    chk("wr_c2_wait", DL_WAIT,  0);
    step();
    chk("wr_c3_en",  MEM_EN, 0);
    chk("wr_c3_we",  MEM_WE, 0);
    chk("wr_ram",    ram[12'h010], 8'h3C);

    // Starvation bound: read in flight, then a buffered write with CPU_RD held
    CPU_RD = 1'b1; CPU_ADDR = 12'h123;
    step();
    DL_WR = 1'b1; DL_ADDR = 12'h020; DL_DATA = 8'h5A;
    step();
    DL_WR = 1'b0;
    chk("starve_wait", DL_WAIT, 1);
    rd_pend = 0; got_wr = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (MEM_EN && MEM_WE) begin
        got_wr = 1;
        chk("starve_defer_clr", dut.r_defer_cnt, 0);
        chk("starve_wr_addr",   MEM_ADDR, 12'h020);
        chk("starve_wr_wait",   DL_WAIT, 0);
        break;
      end
      if (MEM_EN && !MEM_WE && DL_WAIT) rd_pend++;
    end
    chk("starve_got_wr", got_wr, 1);
    chk("starve_reads", rd_pend, 4);
    step();
    chk("starve_idle_gap", MEM_EN, 0);
    step();
    chk("starve_rd_resume_en", MEM_EN, 1);
    chk("starve_rd_resume_we", MEM_WE, 0);
    wait_ack(ok);
    chk("starve_ack_seen", ok, 1);
    chk("starve_ack_data", CPU_DATA, 8'hA5);
    CPU_RD = 1'b0;
    step();
    step();
    chk("starve_ram", ram[12'h020], 8'h5A);

    // Back-to-back 0x400-byte stream
    w0 = wr_cnt; push_fail = 0;
    for (int i = 0; i < 1024; i++) begin
      push_byte(12'h400 + 12'(i), 8'(i * 7 + 3), ok);
      if (!ok) push_fail++;
    end
    step(); step(); step();
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (ram[12'h400 + 12'(i)] !== 8'(i * 7 + 3)) bad++;
    end
    chk("stream_push_ok", push_fail, 0);
    chk("stream_bytes",   bad, 0);
    chk("stream_writes",  wr_cnt - w0, 1024);
    chk("stream_no_done", DL_DONE, 0);

    // DL_ACTIVE falls with a byte buffered: write first, then a single DL_DONE
    DL_WR = 1'b1; DL_ADDR = 12'h050; DL_DATA = 8'h77;
    step();
    DL_WR = 1'b0; DL_ACTIVE = 1'b0;
    chk("done_c1_wait", DL_WAIT, 1);
    chk("done_c1_done", DL_DONE, 0);
    step();
    chk("done_c2_we",   MEM_WE,   1);
    chk("done_c2_addr", MEM_ADDR, 12'h050);
    chk("done_c2_done", DL_DONE,  0);
    step();
    chk("done_c3_done", DL_DONE, 0);
    step();
    chk("done_c4_done", DL_DONE, 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (DL_DONE) pulses++;
    end
    chk("done_no_second", pulses, 0);
    chk("done_ram", ram[12'h050], 8'h77);

    // Reset in RD1 with the buffer full
    CPU_RD = 1'b1; CPU_ADDR = 12'h123;
    DL_WR = 1'b1; DL_ADDR = 12'h060; DL_DATA = 8'h99;
    step();
    chk("rst_pre_en",   MEM_EN,  1);
    chk("rst_pre_wait", DL_WAIT, 1);
    w0 = wr_cnt;
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_en",   MEM_EN,   0);
    chk("rst_mid_addr", MEM_ADDR, 0);
    chk("rst_mid_wait", DL_WAIT,  0);
    chk("rst_mid_data", CPU_DATA, 0);
    chk("rst_mid_ack",  CPU_ACK,  0);
    CPU_RD = 1'b0; DL_WR = 1'b0;
    step();
    RESET = 1'b0;
    step();
    CPU_RD = 1'b1; CPU_ADDR = 12'h400;
    step();
    wait_ack(ok);
    CPU_RD = 1'b0;
    chk("rst_post_ack",  ok, 1);
    chk("rst_post_data", CPU_DATA, 8'h03);
    step(); step();
    chk("rst_byte_dropped", wr_cnt - w0, 0);

`ifdef ROMLOAD_CKSUM_EN
    // 0x102 bytes of 0xFF: 0x102 * 0xFF = 0x100FE, wraps to 0x00FE
    DL_ACTIVE = 1'b1;
    step();
    chk("ck_clear", CKSUM, 16'h0000);
    push_fail = 0;
    for (int i = 0; i < 258; i++) begin
      push_byte(12'h800 + 12'(i), 8'hFF, ok);
      if (!ok) push_fail++;
    end
    DL_ACTIVE = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (DL_DONE) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ck_push_ok", push_fail, 0);
    chk("ck_done",    ok, 1);
    chk("ck_value",   CKSUM, 16'h00FE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
